instr_override: RTL and testbench
=================================

INSTR_OVERRIDE -- requirements
Module: instr_override

Interface
REQ-001 Parameter WIDTH, default 2, instruction field width in bits.
REQ-002 Parameter CNT_W, default 4, force-window counter width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 instruct  input  WIDTH  incoming instruction code, e.g. from the JNO stage.
REQ-006 in_valid  input  1  instruct is valid this cycle.
REQ-007 in_ready  output  1  block accepts instruct this cycle.
REQ-008 enabled  input  1  force request; opens a force window.
REQ-009 force_len  input  CNT_W  number of cycles the window lasts after the enabled cycle; all-ones means unlimited.
REQ-010 force_mask  input  WIDTH  bits ORed into forced instructions.
REQ-011 release  input  1  closes any open force window.
REQ-012 instructA  output  WIDTH  registered output instruction.
REQ-013 out_valid  output  1  instructA is valid.
REQ-014 out_ready  input  1  downstream accepts instructA.
REQ-015 forcing  output  1  force window open (registered state, excludes current-cycle enabled).
REQ-016 forced_count  output  8  saturating count of forced transfers.

Function
REQ-017 Input transfer occurs when in_valid and in_ready are both 1; in_ready = !out_valid || out_ready (combinational).
REQ-018 force_now = enabled || (cnt != 0) || hold, evaluated in the transfer cycle.
REQ-019 On transfer, instructA <= force_now ? (instruct | force_mask) : instruct, and out_valid <= 1; latency 1 cycle.
REQ-020 Without a transfer, out_valid <= 0 if out_ready = 1; otherwise instructA and out_valid hold unchanged.
REQ-021 FSM states: IDLE (cnt = 0, hold = 0), TIMED (cnt != 0), HOLD (hold = 1); forcing = 1 in TIMED or HOLD.
REQ-022 IDLE/TIMED, enabled = 1, force_len = 0: no window after this cycle; next state IDLE, cnt = 0.
REQ-023 enabled = 1, force_len in 1..2^CNT_W-2: cnt <= force_len, next state TIMED; this retriggers an open timed window.
REQ-024 enabled = 1, force_len = all-ones: hold <= 1, cnt <= 0, next state HOLD.
REQ-025 TIMED without enabled: cnt decrements by 1 each cycle, independent of transfers or stalls; at cnt = 1 -> IDLE.
REQ-026 HOLD persists until release; enabled in HOLD with a finite force_len converts to TIMED with cnt <= force_len.
REQ-027 release = 1: cnt <= 0, hold <= 0, next state IDLE, overriding enabled in the same cycle; a same-cycle transfer is still forced if enabled = 1.
REQ-028 forced_count increments by 1 on each forced transfer and saturates at 255 (no wrap).
REQ-029 Stalled output (out_valid = 1, out_ready = 0) blocks input; no instruction is dropped or duplicated.

Reset
REQ-030 reset = 1 at a clock edge: out_valid = 0, instructA = 0, cnt = 0, hold = 0, forcing = 0, forced_count = 0, state IDLE.
REQ-031 reset overrides every other input in the same cycle, including an in-flight transfer or an open window.
REQ-032 in_ready = 1 in the first cycle after reset is released.

Verification (WIDTH = 2, CNT_W = 4, force_mask = 2'b11 unless stated)
REQ-033 Pass-through: instruct = 2'b01, in_valid = 1, enabled = 0 -> next cycle instructA = 2'b01, out_valid = 1, forced_count = 0.
REQ-034 Timed window: enabled = 1, force_len = 3 at cycle 0, instruct = 2'b00 streamed every cycle -> outputs 2'b11 for inputs of cycles 0-3, 2'b00 from cycle 4; forcing = 1 in cycles 1-3; forced_count = 4.
REQ-035 Hold and release: enabled = 1, force_len = 4'hF, then 20 idle cycles -> forcing stays 1; release at cycle 21 -> forcing = 0 at cycle 22; an instruct = 2'b10 accepted at cycle 22 emerges as 2'b10.
REQ-036 Backpressure: out_ready = 0 for 5 cycles with in_valid = 1 -> in_ready = 0, instructA stable; out_ready = 1 -> one transfer per cycle, in order, no loss.
REQ-037 Simultaneous events and saturation: release and enabled (force_len = 2) in the same cycle -> that cycle's transfer is forced, forcing = 0 the next cycle; 300 forced transfers -> forced_count = 255.
REQ-038 Reset mid-window: reset at cnt = 2 while out_valid = 1 -> next cycle out_valid = 0, forcing = 0, forced_count = 0.

Source files
------------

// File: rtl/instr_override.sv
// -----------------------------------------------------------------------------
// instr_override
//
// Registered one-deep instruction stage that can OR a mask into the
// instructions passing through it while a "force window" is open.
//
// Ports
//   clk            single clock, all state updates on its rising edge
//   reset          synchronous active-high reset
//   instruct       incoming instruction code (WIDTH bits)
//   in_valid       instruct is valid this cycle
//   in_ready       stage accepts instruct this cycle (combinational)
//   enabled        force request; opens a force window
//   force_len      window length in cycles after the enabled cycle,
//                  all-ones = unlimited (held until release_req)
//   force_mask     bits ORed into forced instructions
//   release_req    closes any open force window
//   instructA      registered output instruction
//   out_valid      instructA is valid
//   out_ready      downstream accepts instructA
//   forcing        force window currently open (registered)
//   forced_count   saturating count of forced transfers
// -----------------------------------------------------------------------------
module instr_override #(
   parameter int WIDTH = 2,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] instruct,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             enabled,
   input  logic [CNT_W-1:0] force_len,
   input  logic [WIDTH-1:0] force_mask,
   input  logic             release_req,
   output logic [WIDTH-1:0] instructA,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             forcing,
   output logic [7:0]       forced_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TIMED = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LEN_UNLIMITED = '1;
   localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             hold_reg;
   logic             forcing_reg;

   logic [WIDTH-1:0] instr_reg;
   logic             valid_reg;
   logic [7:0]       count_reg;

   logic             xfer;
   logic             force_now;
   logic [WIDTH-1:0] instr_next;

   // The output register can take a new word when it is empty or being drained.
   assign in_ready  = !valid_reg || out_ready;
   assign xfer      = in_valid && in_ready;
   // The enabled cycle itself is forced, as is every cycle of an open window.
   assign force_now = enabled || (cnt_reg != '0) || hold_reg;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
         assign instr_next[gi] = instruct[gi] | (force_now & force_mask[gi]);
      end
   endgenerate

   // Force-window FSM. release_req has priority over enabled; the window
   // counter runs independently of the data handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         hold_reg    <= 1'b0;
         forcing_reg <= 1'b0;
      end else if (release_req) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         hold_reg    <= 1'b0;
         forcing_reg <= 1'b0;
      end else if (enabled) begin
         if (force_len == '0) begin
            // Only the enabled cycle is forced; no window follows.
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            hold_reg    <= 1'b0;
            forcing_reg <= 1'b0;
         end else if (force_len == LEN_UNLIMITED) begin
            state_reg   <= HOLD;
            cnt_reg     <= '0;
            hold_reg    <= 1'b1;
            forcing_reg <= 1'b1;
         end else begin
            // Also retriggers an open timed window and converts HOLD to TIMED.
            state_reg   <= TIMED;
            cnt_reg     <= force_len;
            hold_reg    <= 1'b0;
            forcing_reg <= 1'b1;
         end
      end else begin
         case (state_reg)
            TIMED: begin
               cnt_reg <= cnt_reg - CNT_ONE;
               if (cnt_reg == CNT_ONE) begin
                  state_reg   <= IDLE;
                  forcing_reg <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Output register and forced-transfer counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_reg <= '0;
         valid_reg <= 1'b0;
         count_reg <= '0;
      end else if (xfer) begin
         instr_reg <= instr_next;
         valid_reg <= 1'b1;
         if (force_now && (count_reg != 8'hFF)) begin
            count_reg <= count_reg + 8'd1;
         end
      end else if (out_ready) begin
         valid_reg <= 1'b0;
      end
   end

   assign instructA    = instr_reg;
   assign out_valid    = valid_reg;
   assign forcing      = forcing_reg;
   assign forced_count = count_reg;

endmodule

// File: tb/tb_instr_override.sv
// -----------------------------------------------------------------------------
// tb_instr_override
//
// Scoreboard bench for instr_override (WIDTH = 2, CNT_W = 4). Each driven
// cycle the bench predicts handshake, window state and the forced word; the
// predicted word is queued on transfer and compared while it sits in the
// output register.
// -----------------------------------------------------------------------------
module tb_instr_override;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] instruct;
   logic       in_valid;
   logic       in_ready;
   logic       enabled;
   logic [3:0] force_len;
   logic [1:0] force_mask;
   logic       release_req;
   logic [1:0] instructA;
   logic       out_valid;
   logic       out_ready;
   logic       forcing;
   logic [7:0] forced_count;

   always #5 clk = ~clk;

   instr_override #(.WIDTH(2), .CNT_W(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .instruct     (instruct),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .enabled      (enabled),
      .force_len    (force_len),
      .force_mask   (force_mask),
      .release_req  (release_req),
      .instructA    (instructA),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .forcing      (forcing),
      .forced_count (forced_count)
   );

   int         vectors     = 0;
   int         miscompares = 0;

   logic [1:0] exp_q[$];
   int         m_rem   = 0;
   bit         m_hold  = 1'b0;
   int         m_count = 0;
   bit         last_xfer;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle with the currently driven inputs: check outputs before the
   // edge, advance the reference model, then return #1 after the edge.
   task automatic cycle();
      bit         exp_ready;
      bit         fnow;
      logic [1:0] word;
      @(negedge clk);
      exp_ready = (exp_q.size() == 0) || out_ready;
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("forcing", 32'(forcing), 32'((m_rem != 0) || m_hold));
      check("forced_count", 32'(forced_count), 32'(m_count));
      if (exp_q.size() != 0) begin
         check("instructA", 32'(instructA), 32'(exp_q[0]));
         if (out_ready) void'(exp_q.pop_front());
      end
      last_xfer = in_valid && exp_ready && !reset;
      fnow = enabled || (m_rem != 0) || m_hold;
      if (last_xfer) begin
         word = fnow ? (instruct | force_mask) : instruct;
         exp_q.push_back(word);
         if (fnow && m_count < 255) m_count++;
      end
      if (release_req) begin
         m_rem = 0; m_hold = 1'b0;
      end else if (enabled) begin
         if (force_len == 4'd0) begin
            m_rem = 0; m_hold = 1'b0;
         end else if (force_len == 4'hF) begin
            m_rem = 0; m_hold = 1'b1;
         end else begin
            m_rem = int'(force_len); m_hold = 1'b0;
         end
      end else if (m_rem > 0) begin
         m_rem--;
      end
      if (reset) begin
         exp_q.delete();
         m_rem = 0; m_hold = 1'b0; m_count = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; enabled = 1'b0; release_req = 1'b0;
      force_len = 4'd0; instruct = 2'b00; out_ready = 1'b1; force_mask = 2'b11;
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      // reset state
      check("rst_instructA", 32'(instructA), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_forcing", 32'(forcing), 32'd0);
      check("rst_count", 32'(forced_count), 32'd0);
      cycle();
      reset = 1'b0;

      // pass-through
      in_valid = 1'b1; instruct = 2'b01;
      cycle();
      in_valid = 1'b0;
      cycle();
      check("pass_count", 32'(forced_count), 32'd0);

      // timed window of 3 cycles after the enabled cycle
      in_valid = 1'b1; instruct = 2'b00; enabled = 1'b1; force_len = 4'd3;
      cycle();
      enabled = 1'b0;
      repeat (6) cycle();
      in_valid = 1'b0;
      cycle();
      check("timed_count", 32'(forced_count), 32'd4);

      // hold, then release, then a pass-through word
      enabled = 1'b1; force_len = 4'hF;
      cycle();
      enabled = 1'b0;
      repeat (20) cycle();
      check("hold_forcing", 32'(forcing), 32'd1);
      release_req = 1'b1;
      cycle();
      release_req = 1'b0;
      check("rel_forcing", 32'(forcing), 32'd0);
      in_valid = 1'b1; instruct = 2'b10;
      cycle();
      in_valid = 1'b0;
      cycle();

      // backpressure: source advances only on an accepted word
      out_ready = 1'b0; in_valid = 1'b1; instruct = 2'b01;
      repeat (5) begin
         cycle();
         if (last_xfer) instruct = instruct + 2'b01;
      end
      out_ready = 1'b1;
      repeat (6) begin
         cycle();
         if (last_xfer) instruct = instruct + 2'b01;
      end
      in_valid = 1'b0;
      repeat (2) cycle();

      // simultaneous release and enabled: this transfer forced, no window
      release_req = 1'b1; enabled = 1'b1; force_len = 4'd2;
      in_valid = 1'b1; instruct = 2'b00;
      cycle();
      release_req = 1'b0; enabled = 1'b0; in_valid = 1'b0;
      check("simul_forcing", 32'(forcing), 32'd0);
      cycle();

      // random mix of requests, lengths, masks and stalls
      for (int i = 0; i < 200; i++) begin
         if (last_xfer || !in_valid) instruct = 2'($urandom_range(0, 3));
         in_valid    = ($urandom_range(0, 3) != 0);
         out_ready   = ($urandom_range(0, 3) != 0);
         enabled     = ($urandom_range(0, 9) == 0);
         release_req = ($urandom_range(0, 19) == 0);
         force_len   = 4'($urandom_range(0, 15));
         force_mask  = 2'($urandom_range(1, 3));
         cycle();
      end
      idle_inputs();
      repeat (3) cycle();

      // saturation under an unlimited window
      enabled = 1'b1; force_len = 4'hF; in_valid = 1'b1;
      cycle();
      enabled = 1'b0;
      for (int i = 0; i < 300; i++) begin
         instruct = 2'($urandom_range(0, 3));
         cycle();
      end
      in_valid = 1'b0; release_req = 1'b1;
      cycle();
      release_req = 1'b0;
      check("sat_count", 32'(forced_count), 32'd255);

      // reset mid-window with a word in the output register
      enabled = 1'b1; force_len = 4'd5; in_valid = 1'b1; instruct = 2'b00;
      cycle();
      enabled = 1'b0;
      repeat (3) cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0; in_valid = 1'b0;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_forcing", 32'(forcing), 32'd0);
      check("mid_rst_count", 32'(forced_count), 32'd0);
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
